sipo_frame_capture: RTL and testbench



---
 rtl/sipo_frame_capture_if.sv | 58 +++++
 rtl/sipo_frame_capture.sv | 166 ++++++++++++++++
 tb/tb_sipo_frame_capture.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_capture_if.sv
// ---------------------------------------------------------------------------
// sipo_frame_capture_if
//
// Groups the serial input, the one-entry output buffer handshake and the
// status pulses of sipo_frame_capture.
//
// Handshake: a word transfers on every clk edge where out_valid=1 and
// out_ready=1. out_valid only falls after such a transfer, and out_data is
// held stable while out_valid=1 and out_ready=0.
//
// Signals:
//   sin          serial data from the shift-register output
//   sin_en       bit strobe, sin is only sampled when sin_en=1
//   out_data     captured word held in the output buffer
//   out_valid    out_data holds an unconsumed word
//   out_ready    consumer accepts out_data when out_valid=1
//   busy         receiver is inside a frame (data bits or stop bit)
//   frame_err    one-cycle pulse, bad stop bit
//   overrun_err  one-cycle pulse, good word dropped because buffer full
//
// Modports:
//   slave   the capture block (consumes sin, produces the word)
//   master  the serial source / word consumer side
// ---------------------------------------------------------------------------
interface sipo_frame_capture_if #(
    parameter int WIDTH = 8
) ();
    logic             sin;
    logic             sin_en;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun_err;

    modport slave (
        input  sin,
        input  sin_en,
        input  out_ready,
        output out_data,
        output out_valid,
        output busy,
        output frame_err,
        output overrun_err
    );

    modport master (
        output sin,
        output sin_en,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  busy,
        input  frame_err,
        input  overrun_err
    );
endinterface

// File: rtl/sipo_frame_capture.sv
// ---------------------------------------------------------------------------
// sipo_frame_capture
//
// Serial-to-parallel frame receiver. Waits for a start bit, shifts in WIDTH
// data bits (one per sin_en strobe), checks the stop bit and hands the word
// to a one-entry valid/ready output buffer. Bad stop bits and words lost to
// a full buffer are reported as one-cycle pulses. All outputs are registered.
//
// Parameters:
//   WIDTH        data bits per frame (2..32)
//   MSB_FIRST    0: first data bit lands in bit 0; 1: in bit WIDTH-1
//   START_LEVEL  line level of the start bit; stop bit is its inverse
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   bus        sipo_frame_capture_if.slave (serial in, word out, status)
//   dbg_state  current FSM state (IDLE=0, SHIFT=1, STOP=2)
// ---------------------------------------------------------------------------
module sipo_frame_capture #(
    parameter int WIDTH       = 8,
    parameter bit MSB_FIRST   = 1'b0,
    parameter bit START_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    sipo_frame_capture_if.slave   bus,
    output logic [1:0]            dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] STOP  = 2'd2;

    // Receiver state
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    // Output buffer and status registers
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             busy_q;
    logic             ferr_q;
    logic             oerr_q;

    // Per-cycle events
    logic stop_good;
    logic stop_bad;
    logic consume;
    logic load;
    logic drop;

    // -----------------------------------------------------------------------
    // Receiver next-state logic. Nothing moves unless sin_en is high.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        stop_good = 1'b0;
        stop_bad  = 1'b0;

        if (bus.sin_en) begin
            case (state_q)
                IDLE: begin
                    // A line resting at the stop level is simply ignored.
                    if (bus.sin == START_LEVEL) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end
                end

                SHIFT: begin
                    // Shifting towards the far end means that after WIDTH
                    // bits the first received bit sits at bit 0 (LSB first)
                    // or at bit WIDTH-1 (MSB first), with no final reorder.
                    if (MSB_FIRST) begin
                        shreg_d = {shreg_q[WIDTH-2:0], bus.sin};
                    end else begin
                        shreg_d = {bus.sin, shreg_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end

                STOP: begin
                    // Either outcome frees the line; a start bit on the very
                    // next strobe is accepted from IDLE.
                    state_d = IDLE;
                    if (bus.sin != START_LEVEL) begin
                        stop_good = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer decisions. A consume in the same cycle as a good stop bit
    // frees the slot, so the new word replaces the old one with no bubble.
    // -----------------------------------------------------------------------
    always_comb begin
        consume = valid_q & bus.out_ready;
        load    = stop_good & (~valid_q | consume);
        drop    = stop_good & valid_q & ~consume;
    end

    // -----------------------------------------------------------------------
    // Receiver registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers. busy follows the next state so that it is high on
    // exactly the cycles the receiver spends in SHIFT or STOP.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            ferr_q <= stop_bad;
            oerr_q <= drop;
            if (load) begin
                // The word is complete in shreg_q while in STOP.
                data_q  <= shreg_q;
                valid_q <= 1'b1;
            end else if (consume) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
    assign bus.busy        = busy_q;
    assign bus.frame_err   = ferr_q;
    assign bus.overrun_err = oerr_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_sipo_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_sipo_frame_capture
//
// Drives one LSB-first and one MSB-first capture block (WIDTH=8,
// START_LEVEL=0) with the same serial stream. A frame-level reference model
// (bit queue + buffer flag) predicts every registered output each cycle;
// a vector table and hand-written sequences add fixed expected values.
// ---------------------------------------------------------------------------
module tb_sipo_frame_capture;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    logic sin;
    logic sin_en;
    logic out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sipo_frame_capture_if #(.WIDTH(W)) if_lsb ();
    sipo_frame_capture_if #(.WIDTH(W)) if_msb ();

    logic [1:0] st_lsb;
    logic [1:0] st_msb;

    assign if_lsb.sin       = sin;
    assign if_lsb.sin_en    = sin_en;
    assign if_lsb.out_ready = out_ready;
    assign if_msb.sin       = sin;
    assign if_msb.sin_en    = sin_en;
    assign if_msb.out_ready = out_ready;

    sipo_frame_capture #(.WIDTH(W), .MSB_FIRST(1'b0), .START_LEVEL(1'b0)) u_lsb (
        .clk       (clk),
        .reset     (reset),
        .bus       (if_lsb),
        .dbg_state (st_lsb)
    );

    sipo_frame_capture #(.WIDTH(W), .MSB_FIRST(1'b1), .START_LEVEL(1'b0)) u_msb (
        .clk       (clk),
        .reset     (reset),
        .bus       (if_msb),
        .dbg_state (st_msb)
    );

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame level view: "inside a frame" flag plus the data bits collected so
    // far; the stop bit is the strobe that arrives once W bits are held.
    logic       m_active = 1'b0;
    logic       bits_q[$];
    logic [W-1:0] m_data[2] = '{default: '0};
    logic       m_valid = 1'b0;
    logic       m_busy  = 1'b0;
    logic       m_ferr  = 1'b0;
    logic       m_oerr  = 1'b0;
    logic       m_consume;
    logic       m_good;
    logic       mon_en = 1'b0;

    function automatic logic [W-1:0] word_of(input bit msb);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (msb) w[W-1-i] = bits_q[i];
            else     w[i]     = bits_q[i];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        m_consume = m_valid && out_ready;
        m_good    = 1'b0;
        m_ferr    = 1'b0;
        m_oerr    = 1'b0;
        if (reset) begin
            m_active  = 1'b0;
            bits_q.delete();
            m_data[0] = '0;
            m_data[1] = '0;
            m_valid   = 1'b0;
        end else begin
            if (sin_en) begin
                if (!m_active) begin
                    if (sin == 1'b0) begin
                        m_active = 1'b1;
                        bits_q.delete();
                    end
                end else if (bits_q.size() < W) begin
                    bits_q.push_back(sin);
                end else begin
                    m_active = 1'b0;
                    if (sin == 1'b1) m_good = 1'b1;
                    else             m_ferr = 1'b1;
                end
            end
            if (m_good) begin
                if (!m_valid || m_consume) begin
                    m_data[0] = word_of(1'b0);
                    m_data[1] = word_of(1'b1);
                    m_valid   = 1'b1;
                end else begin
                    m_oerr = 1'b1;
                end
            end else if (m_consume) begin
                m_valid = 1'b0;
            end
        end
        m_busy = m_active;
    end

    // Every cycle, away from the active edge, both DUTs against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            check("lsb_data",  {24'd0, if_lsb.out_data}, {24'd0, m_data[0]});
            check("lsb_valid", {31'd0, if_lsb.out_valid}, {31'd0, m_valid});
            check("lsb_busy",  {31'd0, if_lsb.busy}, {31'd0, m_busy});
            check("lsb_ferr",  {31'd0, if_lsb.frame_err}, {31'd0, m_ferr});
            check("lsb_oerr",  {31'd0, if_lsb.overrun_err}, {31'd0, m_oerr});
            check("msb_data",  {24'd0, if_msb.out_data}, {24'd0, m_data[1]});
            check("msb_valid", {31'd0, if_msb.out_valid}, {31'd0, m_valid});
            check("msb_busy",  {31'd0, if_msb.busy}, {31'd0, m_busy});
            check("msb_ferr",  {31'd0, if_msb.frame_err}, {31'd0, m_ferr});
            check("msb_oerr",  {31'd0, if_msb.overrun_err}, {31'd0, m_oerr});
        end
    end

    // ---------------- driver tasks ----------------
    int busy_cnt;

    // Called at a negedge: drive inputs, return at the next negedge.
    task automatic step(input logic en, input logic s);
        sin    = s;
        sin_en = en;
        @(negedge clk);
        if (if_lsb.busy) busy_cnt++;
    endtask

    // Sends the first nbits of seq (seq[9] first), with gap-1 idle cycles
    // carrying random line noise after every strobe but the last one sent.
    task automatic send_frame(input logic [9:0] seq, input int gap, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            step(1'b1, seq[9-b]);
            if (b != nbits - 1) begin
                for (int g = 1; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)));
            end
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f[9] = 1'b0;
        for (int i = 0; i < 8; i++) f[8-i] = d[i];
        f[0] = stop;
        return f;
    endfunction

    task automatic check_outs(input string tag, input logic [7:0] exp_l, input logic [7:0] exp_m,
                              input logic exp_v, input logic exp_f, input logic exp_o);
        check({tag, "_lsb_data"}, {24'd0, if_lsb.out_data}, {24'd0, exp_l});
        check({tag, "_msb_data"}, {24'd0, if_msb.out_data}, {24'd0, exp_m});
        check({tag, "_valid"}, {31'd0, if_lsb.out_valid}, {31'd0, exp_v});
        check({tag, "_ferr"},  {31'd0, if_lsb.frame_err}, {31'd0, exp_f});
        check({tag, "_oerr"},  {31'd0, if_lsb.overrun_err}, {31'd0, exp_o});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [9:0] seq;
        int         gap;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{seq: 10'b0101001011, gap: 1, exp_lsb: 8'hA5, exp_msb: 8'hA5, exp_ferr: 1'b0};
        vecs[1] = '{seq: 10'b0101001011, gap: 3, exp_lsb: 8'hA5, exp_msb: 8'hA5, exp_ferr: 1'b0};
        vecs[2] = '{seq: 10'b0110000001, gap: 3, exp_lsb: 8'h03, exp_msb: 8'hC0, exp_ferr: 1'b0};
        vecs[3] = '{seq: 10'b0101001010, gap: 1, exp_lsb: 8'h00, exp_msb: 8'h00, exp_ferr: 1'b1};
        vecs[4] = '{seq: 10'b0001111001, gap: 1, exp_lsb: 8'h3C, exp_msb: 8'h3C, exp_ferr: 1'b0};
        vecs[5] = '{seq: 10'b0100000001, gap: 2, exp_lsb: 8'h01, exp_msb: 8'h80, exp_ferr: 1'b0};

        reset     = 1'b1;
        sin       = 1'b1;
        sin_en    = 1'b0;
        out_ready = 1'b1;
        busy_cnt  = 0;
        @(negedge clk);
        mon_en = 1'b1;

        // Reset values
        check_outs("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_busy", {31'd0, if_lsb.busy}, 32'd0);
        check("reset_state", {30'd0, st_lsb}, 32'd0);
        reset = 1'b0;
        step(1'b0, 1'b1);

        // Table-driven frames, consumer always ready
        foreach (vecs[k]) begin
            busy_cnt = 0;
            send_frame(vecs[k].seq, vecs[k].gap, 10);
            check_outs($sformatf("vec%0d", k), vecs[k].exp_ferr ? if_lsb.out_data : vecs[k].exp_lsb,
                       vecs[k].exp_ferr ? if_msb.out_data : vecs[k].exp_msb,
                       ~vecs[k].exp_ferr, vecs[k].exp_ferr, 1'b0);
            check($sformatf("vec%0d_state_idle", k), {30'd0, st_lsb}, 32'd0);
            if (vecs[k].gap == 1) check($sformatf("vec%0d_busy_cycles", k), busy_cnt, 32'd9);
            step(1'b0, 1'b1);
            check($sformatf("vec%0d_valid_drop", k), {31'd0, if_lsb.out_valid}, 32'd0);
            check($sformatf("vec%0d_ferr_pulse", k), {31'd0, if_lsb.frame_err}, 32'd0);
        end

        // Backpressure: second word overruns, first stays put
        out_ready = 1'b0;
        send_frame(frame_of(8'h11, 1'b1), 1, 10);
        check_outs("bp_first", 8'h11, 8'h88, 1'b1, 1'b0, 1'b0);
        send_frame(frame_of(8'h22, 1'b1), 1, 10);
        check_outs("bp_overrun", 8'h11, 8'h88, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1);
        check_outs("bp_hold", 8'h11, 8'h88, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        step(1'b0, 1'b1);
        check_outs("bp_consumed", 8'h11, 8'h88, 1'b0, 1'b0, 1'b0);

        // Simultaneous consume and load
        out_ready = 1'b0;
        send_frame(frame_of(8'h11, 1'b1), 1, 10);
        send_frame(frame_of(8'h22, 1'b1), 1, 9);
        check_outs("sim_pre", 8'h11, 8'h88, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        step(1'b1, 1'b1);
        check_outs("sim_swap", 8'h22, 8'h44, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        check_outs("sim_after", 8'h22, 8'h44, 1'b0, 1'b0, 1'b0);

        // Reset mid-frame with a word buffered
        out_ready = 1'b0;
        send_frame(frame_of(8'h11, 1'b1), 1, 10);
        send_frame(frame_of(8'h5A, 1'b1), 1, 5);
        reset = 1'b1;
        step(1'b0, 1'b1);
        reset = 1'b0;
        check_outs("rst_mid", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_mid_busy", {31'd0, if_lsb.busy}, 32'd0);
        check("rst_mid_state", {30'd0, st_msb}, 32'd0);
        out_ready = 1'b1;
        step(1'b0, 1'b1);
        send_frame(frame_of(8'h5A, 1'b1), 1, 10);
        check_outs("rst_fresh", 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Random stream against the model
        for (int c = 0; c < 4000; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 499) == 0);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end
        reset = 1'b0;
        step(1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
